collision_detection: RTL and testbench
======================================

Name: collision_detection

Overview:
- Per-frame collision checker for the RPG game engine; sits between the player/enemy position registers and the movement/combat FSMs.
- Compares the 16x16 player sprite against one 16x16 enemy sprite and against the wall map (screen-edge bounds plus one rectangular obstacle).
- Also reports the player's 16-px tile (block) coordinates.
- All outputs are registered.

Parameters:
- SPRITE_SIZE, 16, sprite extent in pixels. The box spans [pos, pos+SPRITE_SIZE] inclusive.
- MAX_X, 639, last legal pixel column of the playfield.
- MAX_Y, 479, last legal pixel row of the playfield.
- OBS_X0, 16, obstacle left edge, in block units.
- OBS_X1, 23, obstacle right edge, in block units, inclusive.
- OBS_Y0, 12, obstacle top edge, in block units.
- OBS_Y1, 17, obstacle bottom edge, in block units, inclusive.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- position  in  20  player position: [19:10]=x, [9:0]=y, unsigned pixels, top-left corner of sprite.
- e_position  in  20  enemy position, same packing as position.
- pblockposx  out  6  player block column = x[9:4].
- pblockposy  out  6  player block row = y[9:4].
- enemyCollide  out  1  player/enemy boxes overlap.
- wallCollide  out  1  player box touches the edge bound or the obstacle.

Behaviour:
- Reset: async assert when rst_n=0. All outputs go to 0 immediately and stay 0 until the first rising clk after release.
- Latency: all outputs are registered. They reflect the inputs sampled at the previous rising edge (1-cycle latency), updated every cycle. No handshake.
- Coordinate extraction: px=position[19:10], py=position[9:0], ex=e_position[19:10], ey=e_position[9:0].
- Arithmetic: all comparisons are unsigned. Use 11-bit intermediates so pos+SPRITE_SIZE never wraps.
- enemyCollide = 1 iff |px-ex| <= SPRITE_SIZE and |py-ey| <= SPRITE_SIZE.
  - Equivalent form: ex <= px+16, px <= ex+16, ey <= py+16, py <= ey+16.
  - Touching edges counts as a collision: offset 16 collides, offset 17 does not.
  - Symmetric in player/enemy.
- Wall condition 1, edge: px+SPRITE_SIZE > MAX_X or py+SPRITE_SIZE > MAX_Y. Position (0,0) is not a wall.
- Wall condition 2, obstacle: the player box [px,px+16]x[py,py+16] overlaps the pixel rectangle [OBS_X0*16, OBS_X1*16+15] x [OBS_Y0*16, OBS_Y1*16+15]. Inclusive bounds on both sides.
- wallCollide = condition 1 OR condition 2.
- enemyCollide and wallCollide are independent and may both be 1 in the same cycle.
- pblockposx/pblockposy are truncations. x >= 1024 is impossible by width, so there is no wrap concern.
- No internal state beyond the output registers: no sticky flags. Changing the inputs clears or sets outputs on the next edge.

Optional Feature:
- Macro: CENTER_BLOCK_EN.
- Defined: pblockposx = (px+8)[9:4] and pblockposy = (py+8)[9:4], i.e. the block containing the sprite centre. Use an 11-bit add; if the result reaches 1024, saturate to 63.
- Undefined (default): top-left block, pblockposx = px[9:4], pblockposy = py[9:4].
- Collision outputs are unaffected either way.

Test Plan:
- Reset: hold rst_n=0 with position=(120,120), e_position=(125,120) -> all outputs 0. After release and one clk -> enemyCollide=1.
- Enemy directions: player (120,120), enemy at (125,120), (120,125), (125,125), (115,120), (115,125), (120,115), (115,115) -> enemyCollide=1 one cycle after each change. Between each, player to (0,0) with enemy unchanged -> enemyCollide=0, wallCollide=0.
- Enemy boundaries: player (120,120), enemy (136,136) -> enemyCollide=1. Enemy (137,137) -> enemyCollide=0. Enemy (104,104) -> 1. Enemy (103,120) -> 0.
- Walls clear: player (48,20) -> wallCollide=0, pblockposx=3, pblockposy=1. Player (128,32) -> wallCollide=0, blocks 8,2. Enemy (136,136) for both -> enemyCollide=0.
- Walls hit: player (623,100) -> wallCollide=0. Player (624,100) -> 1. Player (100,464) -> 1. Player (240,176) -> 1, since it touches the obstacle corner at (256,192). Player (239,100) -> 0.
- CENTER_BLOCK_EN build: player (120,120) -> blocks 8,8. Default build, same position -> blocks 7,7.

Source files
------------

// File: rtl/collision_detection.sv
// Per-frame collision checker: player vs enemy sprite, player vs screen edges and one obstacle.
// Optional macro CENTER_BLOCK_EN reports the block under the sprite centre instead of its top-left corner.
`timescale 1ns/1ps
module collision_detection #(
    parameter int SPRITE_SIZE = 16,
    parameter int MAX_X       = 639,
    parameter int MAX_Y       = 479,
    parameter int OBS_X0      = 16,
    parameter int OBS_X1      = 23,
    parameter int OBS_Y0      = 12,
    parameter int OBS_Y1      = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] position,
    input  logic [19:0] e_position,
    output logic [5:0]  pblockposx,
    output logic [5:0]  pblockposy,
    output logic        enemyCollide,
    output logic        wallCollide
);

    localparam int          BLOCK_PX  = 16;
    localparam logic [10:0] SPR       = 11'(SPRITE_SIZE);
    localparam logic [10:0] LIMIT_X   = 11'(MAX_X);
    localparam logic [10:0] LIMIT_Y   = 11'(MAX_Y);
    localparam logic [10:0] OBS_LEFT  = 11'(OBS_X0 * BLOCK_PX);
    localparam logic [10:0] OBS_RIGHT = 11'(OBS_X1 * BLOCK_PX + BLOCK_PX - 1);
    localparam logic [10:0] OBS_TOP   = 11'(OBS_Y0 * BLOCK_PX);
    localparam logic [10:0] OBS_BOT   = 11'(OBS_Y1 * BLOCK_PX + BLOCK_PX - 1);

    // 11-bit copies so that pos + SPRITE_SIZE can never wrap
    logic [10:0] px, py, ex, ey;
    logic [10:0] pxEnd, pyEnd, exEnd, eyEnd;
    logic        enemyHit, edgeHit, obstacleHit;

    logic [5:0]  blockX_d, blockX_q;
    logic [5:0]  blockY_d, blockY_q;
    logic        enemy_d, enemy_q;
    logic        wall_d, wall_q;

    assign px    = {1'b0, position[19:10]};
    assign py    = {1'b0, position[9:0]};
    assign ex    = {1'b0, e_position[19:10]};
    assign ey    = {1'b0, e_position[9:0]};
    assign pxEnd = px + SPR;
    assign pyEnd = py + SPR;
    assign exEnd = ex + SPR;
    assign eyEnd = ey + SPR;

    always_comb begin
        enemyHit    = (ex <= pxEnd) && (px <= exEnd) && (ey <= pyEnd) && (py <= eyEnd);
        edgeHit     = (pxEnd > LIMIT_X) || (pyEnd > LIMIT_Y);
        obstacleHit = (px <= OBS_RIGHT) && (pxEnd >= OBS_LEFT) &&
                      (py <= OBS_BOT)   && (pyEnd >= OBS_TOP);
        enemy_d     = enemyHit;
        wall_d      = edgeHit || obstacleHit;
    end

`ifdef CENTER_BLOCK_EN
    logic [10:0] pxCentre, pyCentre;

    assign pxCentre = px + 11'd8;
    assign pyCentre = py + 11'd8;

    // a centre past column/row 1023 has no block of its own; clamp to the last one
    always_comb begin
        blockX_d = pxCentre[10] ? 6'h3f : pxCentre[9:4];
        blockY_d = pyCentre[10] ? 6'h3f : pyCentre[9:4];
    end
`else
    always_comb begin
        blockX_d = position[19:14];
        blockY_d = position[9:4];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blockX_q <= '0;
            blockY_q <= '0;
            enemy_q  <= 1'b0;
            wall_q   <= 1'b0;
        end else begin
            blockX_q <= blockX_d;
            blockY_q <= blockY_d;
            enemy_q  <= enemy_d;
            wall_q   <= wall_d;
        end
    end

    assign pblockposx   = blockX_q;
    assign pblockposy   = blockY_q;
    assign enemyCollide = enemy_q;
    assign wallCollide  = wall_q;

endmodule

// File: tb/tb_collision_detection.sv
// Directed bench for collision_detection: expectations come from an independent abs-distance model
// and are queued as stimulus is driven, then popped and checked one clock later.
`timescale 1ns/1ps
module tb_collision_detection;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] position;
    logic [19:0] e_position;
    logic [5:0]  pblockposx;
    logic [5:0]  pblockposy;
    logic        enemyCollide;
    logic        wallCollide;

    typedef struct packed {
        logic       enemy;
        logic       wall;
        logic [5:0] bx;
        logic [5:0] by;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];
    int    compared   = 0;
    int    mismatched = 0;

    always #5 clk = ~clk;

    collision_detection dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .position     (position),
        .e_position   (e_position),
        .pblockposx   (pblockposx),
        .pblockposy   (pblockposy),
        .enemyCollide (enemyCollide),
        .wallCollide  (wallCollide)
    );

    function automatic int absDiff(int a, int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Obstacle occupies blocks 16..23 x 12..17, i.e. pixels 256..383 x 192..287
    function automatic exp_t model(int px, int py, int ex, int ey);
        exp_t r;
        int   bx, by;
        bit   edgeHit, obsHit;
        r.enemy = (absDiff(px, ex) <= 16) && (absDiff(py, ey) <= 16);
        edgeHit = (px + 16 > 639) || (py + 16 > 479);
        obsHit  = (px <= 383) && (px + 16 >= 256) && (py <= 287) && (py + 16 >= 192);
        r.wall  = edgeHit || obsHit;
`ifdef CENTER_BLOCK_EN
        bx = (px + 8) / 16;
        by = (py + 8) / 16;
        if (bx > 63) bx = 63;
        if (by > 63) by = 63;
`else
        bx = px / 16;
        by = py / 16;
`endif
        r.bx = 6'(bx);
        r.by = 6'(by);
        return r;
    endfunction

    task automatic compareField(string tag, string field, logic [5:0] observed, logic [5:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, observed, expected);
        end
    endtask

    task automatic driveInputs(int px, int py, int ex, int ey);
        position   = {10'(px), 10'(py)};
        e_position = {10'(ex), 10'(ey)};
    endtask

    task automatic applyStimulus(string tag, int px, int py, int ex, int ey);
        @(negedge clk);
        driveInputs(px, py, ex, ey);
        expQ.push_back(model(px, py, ex, ey));
        tagQ.push_back(tag);
    endtask

    task automatic checkOutput();
        exp_t  e;
        string t;
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            compareField(t, "enemyCollide", {5'd0, enemyCollide}, {5'd0, e.enemy});
            compareField(t, "wallCollide",  {5'd0, wallCollide},  {5'd0, e.wall});
            compareField(t, "pblockposx",   pblockposx,           e.bx);
            compareField(t, "pblockposy",   pblockposy,           e.by);
        end
    endtask

    task automatic step(string tag, int px, int py, int ex, int ey);
        applyStimulus(tag, px, py, ex, ey);
        checkOutput();
    endtask

    task automatic checkAllZero(string tag);
        compareField(tag, "enemyCollide", {5'd0, enemyCollide}, 6'd0);
        compareField(tag, "wallCollide",  {5'd0, wallCollide},  6'd0);
        compareField(tag, "pblockposx",   pblockposx,           6'd0);
        compareField(tag, "pblockposy",   pblockposy,           6'd0);
    endtask

    int enemyX[8] = '{125, 120, 125, 115, 115, 120, 115, 120};
    int enemyY[8] = '{120, 125, 125, 120, 125, 115, 115, 120};

    initial begin
        // Reset held with overlapping sprites: outputs stay 0 across clock edges
        rst_n = 1'b0;
        driveInputs(120, 120, 125, 120);
        #2;
        checkAllZero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset_held");

        @(negedge clk);
        rst_n = 1'b1;
        expQ.push_back(model(120, 120, 125, 120));
        tagQ.push_back("reset_release");
        checkOutput();

        // Enemy in every direction around the player, with a non-colliding step between
        for (int i = 0; i < 7; i++) begin
            step($sformatf("dir%0d", i), 120, 120, enemyX[i], enemyY[i]);
            step($sformatf("dir%0d_away", i), 0, 0, enemyX[i], enemyY[i]);
        end
        step("dir_overlap", 120, 120, enemyX[7], enemyY[7]);

        // Touching at offset 16 collides, offset 17 does not
        step("enemy_pp16", 120, 120, 136, 136);
        step("enemy_pp17", 120, 120, 137, 137);
        step("enemy_mm16", 120, 120, 104, 104);
        step("enemy_mx17", 120, 120, 103, 120);
        step("enemy_y17",  120, 120, 120, 137);
        step("enemy_swap", 136, 136, 120, 120);

        // Open ground
        step("clear_48_20",  48,  20, 136, 136);
        step("clear_128_32", 128, 32, 136, 136);

        // Screen edges and the obstacle
        step("edge_x623",   623, 100, 0, 0);
        step("edge_x624",   624, 100, 0, 0);
        step("edge_y463",   100, 463, 0, 0);
        step("edge_y464",   100, 464, 0, 0);
        step("obs_corner",  240, 176, 0, 0);
        step("obs_miss",    239, 100, 0, 0);
        step("obs_left",    239, 200, 0, 0);
        step("obs_right",   384, 200, 0, 0);
        step("obs_right_in",383, 287, 0, 0);
        step("obs_below",   300, 288, 0, 0);
        step("far_corner", 1020, 1020, 0, 0);

        // Both flags together, then clear again
        step("both_hit",    624, 100, 630, 110);
        step("both_clear",  120, 120, 400, 400);
        step("centre_blk",  120, 120, 0, 0);
        step("centre_edge", 119, 55, 0, 0);

        // Asynchronous reset mid-cycle with collisions present
        step("pre_reset", 624, 100, 630, 100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("reset_midrun");
        @(negedge clk);
        rst_n = 1'b1;
        expQ.push_back(model(624, 100, 630, 100));
        tagQ.push_back("reset_rerelease");
        checkOutput();

        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
